// File: rtl/key_decoder.sv
// key_decoder: turns the keyboard byte stream into flap / pause / quit commands.
// Optional feature macro: KEY_DECODER_ARROW_EN builds the ESC [ A up-arrow parser.
// Without it, ESC is a quit key and '[' / 'A' are ignored.
// Flaps are rate-limited by a holdoff window and counted in flap_cnt_o.
// All outputs are registered; there is no combinational path from inp_i.
module key_decoder #(
  parameter int unsigned HOLDOFF     = 4,
  parameter int unsigned ESC_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  inp_i,
  output logic        flap_o,
  output logic        pause_o,
  output logic        quit_o,
  output logic [15:0] flap_cnt_o
);

  localparam int unsigned HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);

  localparam logic [7:0] K_SPACE = 8'h20;
  localparam logic [7:0] K_W     = 8'h77;
  localparam logic [7:0] K_P     = 8'h70;
  localparam logic [7:0] K_Q     = 8'h71;
  localparam logic [7:0] K_ESC   = 8'h1B;
`ifdef KEY_DECODER_ARROW_EN
  localparam logic [7:0] K_LBRK  = 8'h5B;
  localparam logic [7:0] K_UP    = 8'h41;
  localparam int unsigned TW = (ESC_TIMEOUT > 0) ? $clog2(ESC_TIMEOUT + 1) : 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd3
`ifdef KEY_DECODER_ARROW_EN
    ,
    S_ESC  = 2'd1,
    S_CSI  = 2'd2
`endif
  } state_e;

  state_e         state_q;
  logic           flap_q;
  logic           pause_q;
  logic           quit_q;
  logic [15:0]    flap_cnt_q;
  logic [HW-1:0]  hold_q;
`ifdef KEY_DECODER_ARROW_EN
  logic [TW-1:0]  timer_q;
  logic           timer_expire;
  logic           byte_empty;
`endif

  logic flap_req;
  logic flap_accept;

`ifdef KEY_DECODER_ARROW_EN
  // An empty cycle that would bring the stall timer up to ESC_TIMEOUT resolves the sequence.
  always_comb begin
    byte_empty   = (inp_i == 8'h00) || (inp_i == 8'hFF);
    timer_expire = (32'(timer_q) + 32'd1) >= ESC_TIMEOUT;
  end
`endif

  // A flap is requested by space/w in IDLE or by the final 'A' of an up-arrow sequence.
  always_comb begin
    flap_req = 1'b0;
    if (state_q == S_IDLE && (inp_i == K_SPACE || inp_i == K_W)) begin
      flap_req = 1'b1;
    end
`ifdef KEY_DECODER_ARROW_EN
    if (state_q == S_CSI && inp_i == K_UP) begin
      flap_req = 1'b1;
    end
`endif
    flap_accept = flap_req && !pause_q && (hold_q == '0);
  end

  // Decoder state machine with registered outputs and holdoff / stall counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      flap_q     <= 1'b0;
      pause_q    <= 1'b0;
      quit_q     <= 1'b0;
      flap_cnt_q <= 16'd0;
      hold_q     <= '0;
`ifdef KEY_DECODER_ARROW_EN
      timer_q    <= '0;
`endif
    end else begin
      flap_q <= flap_accept;
      // Holdoff reloads on acceptance, otherwise drains to zero (also while paused or done).
      if (flap_accept) begin
        flap_cnt_q <= flap_cnt_q + 16'd1;
        hold_q     <= HOLD_LOAD;
      end else if (hold_q != '0) begin
        hold_q <= hold_q - 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (inp_i == K_P) begin
            pause_q <= ~pause_q;
          end else if (inp_i == K_Q) begin
            quit_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (inp_i == K_ESC) begin
`ifdef KEY_DECODER_ARROW_EN
            state_q <= S_ESC;
            timer_q <= '0;
`else
            quit_q  <= 1'b1;
            state_q <= S_DONE;
`endif
          end
        end
`ifdef KEY_DECODER_ARROW_EN
        S_ESC: begin
          if (inp_i == K_LBRK) begin
            state_q <= S_CSI;
            timer_q <= '0;
          end else if (!byte_empty || timer_expire) begin
            // Bare ESC (followed by another key or by silence) means quit.
            quit_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_CSI: begin
          // Any byte ends the sequence; 'A' has already raised flap_req above.
          if (!byte_empty || timer_expire) begin
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
`endif
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign flap_o     = flap_q;
  assign pause_o    = pause_q;
  assign quit_o     = quit_q;
  assign flap_cnt_o = flap_cnt_q;

endmodule

// File: tb/tb_key_decoder.sv
// Self-checking bench for key_decoder: directed scenarios followed by random bytes,
// every cycle compared against a cycle-counting reference model.
module tb_key_decoder;

  localparam int unsigned HOLDOFF     = 4;
  localparam int unsigned ESC_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  inp_i = 8'h00;
  logic        flap_o;
  logic        pause_o;
  logic        quit_o;
  logic [15:0] flap_cnt_o;

  key_decoder #(.HOLDOFF(HOLDOFF), .ESC_TIMEOUT(ESC_TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inp_i      (inp_i),
    .flap_o     (flap_o),
    .pause_o    (pause_o),
    .quit_o     (quit_o),
    .flap_cnt_o (flap_cnt_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int pulses   = 0;

  // Reference model: holdoff tracked as the earliest cycle number a flap may be
  // accepted again; escape parsing tracked as "bytes of sequence seen" plus stall length.
  bit          m_done, m_pause, m_quit, m_flap;
  int          m_cnt, m_cyc, m_next_ok, m_seq, m_stall;

  function automatic void model_reset();
    m_done = 0; m_pause = 0; m_quit = 0; m_flap = 0;
    m_cnt = 0; m_cyc = 0; m_next_ok = 0; m_seq = 0; m_stall = 0;
  endfunction

  function automatic void model_step(input logic [7:0] b);
    bit empty;
    bit req;
    empty = (b == 8'h00) || (b == 8'hFF);
    req = 0;
    m_cyc++;
    m_flap = 0;
    if (m_done) begin
      req = 0;
    end else if (m_seq == 0) begin
      if (b == 8'h20 || b == 8'h77) req = 1;
      else if (b == 8'h70) m_pause = !m_pause;
      else if (b == 8'h71) begin m_quit = 1; m_done = 1; end
      else if (b == 8'h1B) begin
`ifdef KEY_DECODER_ARROW_EN
        m_seq = 1; m_stall = 0;
`else
        m_quit = 1; m_done = 1;
`endif
      end
    end else if (m_seq == 1) begin
      if (b == 8'h5B) begin m_seq = 2; m_stall = 0; end
      else if (!empty) begin m_quit = 1; m_done = 1; m_seq = 0; end
      else begin
        m_stall++;
        if (m_stall >= int'(ESC_TIMEOUT)) begin m_quit = 1; m_done = 1; m_seq = 0; end
      end
    end else begin
      if (!empty) begin
        if (b == 8'h41) req = 1;
        m_seq = 0;
      end else begin
        m_stall++;
        if (m_stall >= int'(ESC_TIMEOUT)) m_seq = 0;
      end
    end
    if (req && !m_pause && m_cyc >= m_next_ok) begin
      m_flap = 1;
      m_cnt = (m_cnt + 1) & 16'hFFFF;
      m_next_ok = m_cyc + int'(HOLDOFF) + 1;
    end
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".flap"},  16'(flap_o),  16'(m_flap));
    chk({tag, ".pause"}, 16'(pause_o), 16'(m_pause));
    chk({tag, ".quit"},  16'(quit_o),  16'(m_quit));
    chk({tag, ".cnt"},   flap_cnt_o,   16'(m_cnt));
  endtask

  // Drive one byte, let the edge take it, then compare everything 1 time unit later.
  task automatic step(input logic [7:0] b, input string tag);
    inp_i = b;
    @(posedge clk);
    model_step(b);
    #1;
    if (flap_o === 1'b1) pulses++;
    check_all(tag);
    $display("step %-10s byte=%02h flap=%b pause=%b quit=%b cnt=%0d", tag, b, flap_o, pause_o, quit_o, flap_cnt_o);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(8'h00, tag);
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs must clear with no clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    $display("reset %-9s flap=%b pause=%b quit=%b cnt=%0d", tag, flap_o, pause_o, quit_o, flap_cnt_o);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 19);
    if (r <= 4) return 8'h00;
    if (r == 5) return 8'hFF;
    if (r <= 8) return 8'h20;
    if (r == 9) return 8'h77;
    if (r == 10) return 8'h70;
    if (r == 11) return ($urandom_range(0, 9) == 0) ? 8'h71 : 8'h00;
    if (r <= 13) return 8'h1B;
    if (r == 14) return 8'h5B;
    if (r == 15) return 8'h41;
    if (r == 16) return 8'h42;
    return 8'($urandom);
  endfunction

  initial begin
    model_reset();
    // Reset state.
    #3;
    check_all("reset");
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;

    // Two spaces six cycles apart: both accepted.
    pulses = 0;
    step(8'h20, "sp1");
    chk("sp1_pulse", 16'(flap_o), 16'd1);
    idle(5, "gap");
    step(8'h20, "sp2");
    chk("sp2_pulse", 16'(flap_o), 16'd1);
    chk("two_pulses", 16'(pulses), 16'd2);
    chk("cnt_two", flap_cnt_o, 16'd2);

    // Holdoff: three consecutive spaces give one pulse.
    idle(5, "drain");
    pulses = 0;
    step(8'h20, "h1"); step(8'h20, "h2"); step(8'h20, "h3");
    chk("holdoff_pulses", 16'(pulses), 16'd1);
    idle(1, "h4");
    step(8'h20, "h5_drop");
    chk("holdoff_edge_drop", 16'(flap_o), 16'd0);
    step(8'h20, "h6_accept");
    chk("holdoff_edge_ok", 16'(flap_o), 16'd1);

    // Pause: p, space, p, 5 empty, space.
    idle(5, "drain");
    pulses = 0;
    step(8'h70, "p_on");
    chk("pause_on", 16'(pause_o), 16'd1);
    step(8'h20, "sp_paused");
    step(8'h70, "p_off");
    chk("pause_off", 16'(pause_o), 16'd0);
    idle(5, "pgap");
    step(8'h20, "sp_run");
    chk("pause_pulses", 16'(pulses), 16'd1);

`ifdef KEY_DECODER_ARROW_EN
    // Up arrow and an unknown CSI sequence.
    idle(5, "drain");
    step(8'h1B, "esc"); step(8'h5B, "lbrk"); step(8'h41, "up");
    chk("arrow_pulse", 16'(flap_o), 16'd1);
    idle(5, "drain");
    pulses = 0;
    step(8'h1B, "esc"); step(8'h5B, "lbrk"); step(8'h42, "B");
    idle(2, "after_B");
    chk("csi_B_silent", 16'(pulses) + 16'(quit_o), 16'd0);
    // Bare ESC times out into quit exactly ESC_TIMEOUT cycles later.
    step(8'h1B, "esc_bare");
    idle(int'(ESC_TIMEOUT) - 1, "esc_wait");
    chk("esc_not_yet", 16'(quit_o), 16'd0);
    idle(1, "esc_tmo");
    chk("esc_timeout_quit", 16'(quit_o), 16'd1);
`else
    // ESC alone quits at once; arrow bytes are ignored.
    idle(5, "drain");
    step(8'h5B, "lbrk_ign"); step(8'h41, "A_ign");
    step(8'h1B, "esc_quit");
    chk("esc_quit", 16'(quit_o), 16'd1);
`endif
    pulses = 0;
    step(8'h20, "sp_done");
    idle(1, "done");
    chk("done_no_pulse", 16'(pulses), 16'd0);

    // Async reset out of DONE with pause and count non-zero.
    async_reset("rst_a");
    step(8'h20, "sp_a"); step(8'h70, "p_a"); step(8'h71, "q_a");
    chk("pre_rst_quit", 16'(quit_o) + 16'(pause_o), 16'd2);
    async_reset("rst_done");
    chk("rst_cnt_clear", flap_cnt_o, 16'd0);
    step(8'h20, "sp_after");
    chk("post_rst_pulse", 16'(flap_o), 16'd1);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) async_reset("rnd_rst");
      step(rand_byte(), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/key_decoder.md
# key_decoder

Converts the raw byte stream from `keyboard` into game commands for `control`: flap pulses, a pause level, and a sticky quit. Parses the ANSI up-arrow escape sequence (ESC `[` `A`) as a flap. Rate-limits flaps with a holdoff window. Counts accepted flaps. Sits between `keyboard` and `control`; all outputs are registered.

## Interface
- `HOLDOFF`, 4: cycles after an accepted flap during which further flap requests are dropped; 0 disables holdoff.
- `ESC_TIMEOUT`, 8: cycles an escape sequence may stall, between bytes, before it is resolved.
- `clk`  in  1  system clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `inp`  in  8  byte from `keyboard`, sampled every posedge.
  - 0x00 = no byte this cycle.
  - 0xFF (EOF artefact) = no byte.
- `flap`  out  1  one-cycle pulse per accepted flap.
- `pause`  out  1  pause level; toggled by `p`.
- `quit`  out  1  sticky; high from the quit event until reset.
- `flap_cnt`  out  16  number of accepted flaps; wraps 0xFFFF→0x0000.

## Operation
- **States:** IDLE, ESC, CSI, DONE.
- **Reset values:** state=IDLE; `flap`=0, `pause`=0, `quit`=0, `flap_cnt`=0; holdoff counter=0; timeout counter=0.
- **IDLE**
  - `space` or `w`: flap request.
  - `p`: toggle `pause`.
  - `q`: `quit`=1, go to DONE.
  - ESC (0x1B): go to ESC, timer=0.
  - Any other byte: ignored.
- **ESC**
  - `[`: go to CSI, timer=0.
  - Any other non-empty byte: bare ESC. Set `quit`=1, go to DONE. The byte is discarded.
  - Empty cycle: timer+1. When timer reaches ESC_TIMEOUT: `quit`=1, go to DONE.
- **CSI**
  - `A`: flap request, go to IDLE.
  - Any other non-empty byte: discard, go to IDLE.
  - Empty cycle: timer+1. When timer reaches ESC_TIMEOUT: silently go to IDLE.
- **DONE:** all input ignored. `flap`=0. `pause` and `flap_cnt` are frozen. Only reset exits.
- **Flap acceptance:** a request is accepted iff `pause`=0 and holdoff counter=0. On acceptance:
  - `flap`=1 for one cycle.
  - `flap_cnt`+1.
  - Holdoff counter=HOLDOFF.
- **Rejected requests:** no output, no counter change, holdoff not reloaded.
- **Holdoff counter:** decrements by 1 every cycle while nonzero, including while paused.
- **Counter widths:** `$clog2(HOLDOFF+1)` and `$clog2(ESC_TIMEOUT+1)`, minimum 1 bit.
- **Arithmetic:** no saturation anywhere except holdoff, which stops at 0.

## Timing
- **Latency:** a byte sampled at posedge k produces its output effect from posedge k to posedge k+1. That is one cycle of latency, with no combinational path from `inp` to any output.
- **`flap`:** never high on two consecutive cycles when HOLDOFF≥1.
  - With HOLDOFF=0, back-to-back `space` bytes give back-to-back pulses.
- **Holdoff window:** after an accepted flap at posedge k, requests at posedges k+1…k+HOLDOFF are dropped. A request at k+HOLDOFF+1 is accepted.
- **Escape sequence latency:** ESC, `[`, `A` on consecutive cycles k, k+1, k+2 gives `flap` high at posedge k+2.
- **Escape timeout:** ESC at k followed only by empty cycles gives `quit` high at posedge k+ESC_TIMEOUT.
- **Asynchronous reset mid-sequence** (any state, any counter value): all outputs drop to their reset values immediately, with no clock required. The first byte after `rst_n` rises is decoded from IDLE.

## Configuration
- **`KEY_DECODER_ARROW_EN` defined:** ESC/CSI parsing as above.
- **`KEY_DECODER_ARROW_EN` undefined:**
  - ESC and CSI states are not built.
  - ESC in IDLE immediately sets `quit` and goes to DONE.
  - `[` and `A` are ordinary ignored bytes.
  - ESC_TIMEOUT is unused.

## Test plan
- **Reset, then pause:** reset, then bytes `space`, 0, 0, 0, 0, 0, `space` with HOLDOFF=4 → two `flap` pulses, one cycle after each `space`; `flap_cnt`=2.
- **Holdoff:** `space` on 3 consecutive cycles, HOLDOFF=4 → exactly one pulse; `flap_cnt`=1.
- **Pause:** `p`, `space`, `p`, then 5 empty cycles, then `space` → `pause` is 1 for exactly 2 cycles; one pulse, from the final `space` only; `flap_cnt`=1.
- **Arrow key:** with the macro defined, ESC `[` `A` → `flap` pulse at the posedge after `A`.
- **Unknown sequence and bare ESC:** ESC `[` `B` → no output. Then ESC followed by 8 empty cycles (ESC_TIMEOUT=8) → `quit`=1 at the 8th. Subsequent `space` → no pulse.
- **Async reset from DONE:** `q`, then assert `rst_n`=0 mid-cycle → `quit`, `pause` and `flap_cnt` clear before the next edge. After release, `space` → pulse.
